topk_insertion_buffer: RTL and testbench

TOPK_INSERTION_BUFFER -- requirements
Module: topk_insertion_buffer

---
 rtl/topk_insertion_buffer.sv | 163 ++++++++++++++++
 tb/tb_topk_insertion_buffer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/topk_insertion_buffer.sv
`default_nettype none
// ============================================================================
// Module   : topk_insertion_buffer
// Purpose  : Keeps the K nearest samples of a batch as a sorted list, using
//            insertion into K registered slots. Each slot holds a distance, a
//            class type and a valid bit. Slot 0 is the nearest.
//            When a batch ends, a one-cycle valid_sort pulse marks the final
//            list. The list holds until the next accepted sample.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            sample_valid/_distance/
//            _type/_last              - one-cycle sample strobe and payload
//            k_nearest_neighbours_*   - packed sorted slots, slot 0 in the LSBs
//            k_valid_mask             - bit i set when slot i holds a sample
//            valid_sort               - one-cycle result-ready pulse
//            busy                     - high while a batch is being collected
//            sample_count             - samples accepted in current/last batch
// Revision : 1.0 - initial release
// ============================================================================
module topk_insertion_buffer #(
  parameter int W            = 8,
  parameter int TYPE_W       = 2,
  parameter int K            = 3,
  parameter int MAX_ELEMENTS = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              sample_valid,
  input  logic [W-1:0]                      sample_distance,
  input  logic [TYPE_W-1:0]                 sample_type,
  input  logic                              sample_last,
  output logic [TYPE_W*K-1:0]               k_nearest_neighbours_type,
  output logic [W*K-1:0]                    k_nearest_neighbours_distance,
  output logic [K-1:0]                      k_valid_mask,
  output logic                              valid_sort,
  output logic                              busy,
  output logic [$clog2(MAX_ELEMENTS+1)-1:0] sample_count
);

  localparam int CW = $clog2(MAX_ELEMENTS + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [W-1:0]        r_dist [K];
  logic [TYPE_W-1:0]   r_type [K];
  logic [K-1:0]        r_vld;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic                r_valid_sort;
  logic                w_start;
  logic                w_end;
  logic                w_busy;

  // Per-slot insertion decode. w_qual is monotonic across slots because the
  // list is kept ascending with invalid slots at the top, so the first
  // qualifying slot takes the sample and every slot above it shifts up.
  logic [K-1:0]        w_qual;
  logic [K-1:0]        w_ins;
  logic [K-1:0]        w_shift;
  logic [W-1:0]        w_prev_dist [K];
  logic [TYPE_W-1:0]   w_prev_type [K];
  logic [K-1:0]        w_prev_vld;

  // --------------------------------------------------------------------------
  // FSM: next state, batch start/end decode and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_start     = sample_valid && (r_state != COLLECT);
    w_cnt_nxt   = w_start ? CW'(1) : (r_cnt + CW'(1));
    w_end       = sample_valid &&
                  (sample_last || (w_cnt_nxt == CW'(MAX_ELEMENTS)));
    w_busy      = (r_state == COLLECT);
    if (sample_valid) begin
      w_state_nxt = w_end ? DONE : COLLECT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_valid_sort <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      // The pulse lands in the first DONE cycle; a batch ending again from
      // DONE simply produces another single pulse.
      r_valid_sort <= w_end;
      if (sample_valid) begin
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Slot storage
  // --------------------------------------------------------------------------
  for (genvar i = 0; i < K; i++) begin : g_slot
    // Strict compare gives first-arrival-wins on equal distances; the valid
    // bit lets an all-ones distance sort correctly against empty slots.
    assign w_qual[i] = !r_vld[i] || (r_dist[i] > sample_distance);

    if (i == 0) begin : g_head
      assign w_ins[i]       = w_qual[i];
      assign w_shift[i]     = 1'b0;
      assign w_prev_dist[i] = '1;
      assign w_prev_type[i] = '0;
      assign w_prev_vld[i]  = 1'b0;
    end else begin : g_tail
      assign w_ins[i]       = w_qual[i] && !w_qual[i-1];
      assign w_shift[i]     = w_qual[i-1];
      assign w_prev_dist[i] = r_dist[i-1];
      assign w_prev_type[i] = r_type[i-1];
      assign w_prev_vld[i]  = r_vld[i-1];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_dist[i] <= '1;
        r_type[i] <= '0;
        r_vld[i]  <= 1'b0;
      end else if (w_start) begin
        // New batch: discard the old list and seed slot 0 in one cycle.
        if (i == 0) begin
          r_dist[i] <= sample_distance;
          r_type[i] <= sample_type;
          r_vld[i]  <= 1'b1;
        end else begin
          r_dist[i] <= '1;
          r_type[i] <= '0;
          r_vld[i]  <= 1'b0;
        end
      end else if (sample_valid) begin
        if (w_ins[i]) begin
          r_dist[i] <= sample_distance;
          r_type[i] <= sample_type;
          r_vld[i]  <= 1'b1;
        end else if (w_shift[i]) begin
          r_dist[i] <= w_prev_dist[i];
          r_type[i] <= w_prev_type[i];
          r_vld[i]  <= w_prev_vld[i];
        end
      end
    end

    // Invalid slots already hold all-ones/zero, so the registers drive the
    // outputs directly.
    assign k_nearest_neighbours_distance[i*W +: W]      = r_dist[i];
    assign k_nearest_neighbours_type[i*TYPE_W +: TYPE_W] = r_type[i];
  end

  assign k_valid_mask = r_vld;
  assign valid_sort   = r_valid_sort;
  assign busy         = w_busy;
  assign sample_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_topk_insertion_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_topk_insertion_buffer
// Purpose  : Self-checking bench for topk_insertion_buffer. A behavioural
//            sorted-list model pushes the expected final list when a batch
//            ends; a monitor pops and compares on every valid_sort. Directed
//            checks cover reset, hold, back-to-back batches, mid-batch reset
//            and the MAX_ELEMENTS overflow on a second instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_topk_insertion_buffer;

  localparam int W   = 8;
  localparam int TW  = 2;
  localparam int K   = 3;
  localparam int MAX = 16;
  localparam int CW  = $clog2(MAX + 1);
  localparam int CW4 = $clog2(4 + 1);

  logic          clk = 1'b0;
  logic          rst;
  always #5 clk = ~clk;

  // Main instance (MAX_ELEMENTS = 16)
  logic          sv, sl;
  logic [W-1:0]  sd;
  logic [TW-1:0] st;
  logic [TW*K-1:0] o_type;
  logic [W*K-1:0]  o_dist;
  logic [K-1:0]    o_mask;
  logic            o_vs, o_busy;
  logic [CW-1:0]   o_cnt;

  // Overflow instance (MAX_ELEMENTS = 4)
  logic          sv4, sl4;
  logic [W-1:0]  sd4;
  logic [TW-1:0] st4;
  logic [TW*K-1:0] o_type4;
  logic [W*K-1:0]  o_dist4;
  logic [K-1:0]    o_mask4;
  logic            o_vs4, o_busy4;
  logic [CW4-1:0]  o_cnt4;

  topk_insertion_buffer #(.W(W), .TYPE_W(TW), .K(K), .MAX_ELEMENTS(MAX)) dut (
    .clk                           (clk),
    .rst                           (rst),
    .sample_valid                  (sv),
    .sample_distance               (sd),
    .sample_type                   (st),
    .sample_last                   (sl),
    .k_nearest_neighbours_type     (o_type),
    .k_nearest_neighbours_distance (o_dist),
    .k_valid_mask                  (o_mask),
    .valid_sort                    (o_vs),
    .busy                          (o_busy),
    .sample_count                  (o_cnt)
  );

  topk_insertion_buffer #(.W(W), .TYPE_W(TW), .K(K), .MAX_ELEMENTS(4)) dut4 (
    .clk                           (clk),
    .rst                           (rst),
    .sample_valid                  (sv4),
    .sample_distance               (sd4),
    .sample_type                   (st4),
    .sample_last                   (sl4),
    .k_nearest_neighbours_type     (o_type4),
    .k_nearest_neighbours_distance (o_dist4),
    .k_valid_mask                  (o_mask4),
    .valid_sort                    (o_vs4),
    .busy                          (o_busy4),
    .sample_count                  (o_cnt4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model and scoreboard
  // --------------------------------------------------------------------------
  typedef struct packed {
    logic [W*K-1:0]  d;
    logic [TW*K-1:0] t;
    logic [K-1:0]    m;
    logic [CW-1:0]   c;
  } exp_t;

  exp_t sb[$];
  int   m_d[$];
  int   m_t[$];
  int   m_cnt    = 0;
  bit   m_active = 1'b0;

  function automatic exp_t snap();
    exp_t e;
    e.d = '1;
    e.t = '0;
    e.m = '0;
    for (int i = 0; i < m_d.size(); i++) begin
      e.d[i*W +: W]   = W'(m_d[i]);
      e.t[i*TW +: TW] = TW'(m_t[i]);
      e.m[i]          = 1'b1;
    end
    e.c = CW'(m_cnt);
    return e;
  endfunction

  function automatic void model_accept(input int d, input int t, input bit last);
    int p;
    if (!m_active) begin
      m_d.delete();
      m_t.delete();
      m_cnt = 0;
    end
    p = m_d.size();
    for (int i = 0; i < m_d.size(); i++) begin
      if (m_d[i] > d) begin
        p = i;
        break;
      end
    end
    m_d.insert(p, d);
    m_t.insert(p, t);
    if (m_d.size() > K) begin
      void'(m_d.pop_back());
      void'(m_t.pop_back());
    end
    m_cnt++;
    if (last || m_cnt == MAX) begin
      sb.push_back(snap());
      m_active = 1'b0;
    end else begin
      m_active = 1'b1;
    end
  endfunction

  function automatic void model_reset();
    m_d.delete();
    m_t.delete();
    m_cnt    = 0;
    m_active = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!rst && o_vs) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid_sort", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("sb_dist", o_dist, e.d);
        check_eq("sb_type", o_type, e.t);
        check_eq("sb_mask", o_mask, e.m);
        check_eq("sb_count", o_cnt, e.c);
        check_eq("sb_busy", o_busy, 32'd0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1)
  // --------------------------------------------------------------------------
  task automatic send(input int d, input int t, input bit last);
    sv = 1'b1;
    sd = W'(d);
    st = TW'(t);
    sl = last;
    model_accept(d, t, last);
    @(posedge clk);
    #1;
    sv = 1'b0;
    sl = 1'b0;
  endtask

  task automatic send4(input int d, input int t);
    sv4 = 1'b1;
    sd4 = W'(d);
    st4 = TW'(t);
    sl4 = 1'b0;
    @(posedge clk);
    #1;
    sv4 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_dist"},  o_dist, 32'hFFFFFF);
    check_eq({tag, "_type"},  o_type, 32'd0);
    check_eq({tag, "_mask"},  o_mask, 32'd0);
    check_eq({tag, "_vs"},    o_vs,   32'd0);
    check_eq({tag, "_busy"},  o_busy, 32'd0);
    check_eq({tag, "_count"}, o_cnt,  32'd0);
  endtask

  task automatic check_basic_result(input string tag);
    // {10,20,20} with types {3,2,1}
    check_eq({tag, "_dist"},  o_dist, 32'h14140A);
    check_eq({tag, "_type"},  o_type, 32'h1B);
    check_eq({tag, "_mask"},  o_mask, 32'h7);
    check_eq({tag, "_count"}, o_cnt,  32'd5);
    check_eq({tag, "_vs"},    o_vs,   32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [W*K-1:0]  hold_d;
    logic [TW*K-1:0] hold_t;

    rst = 1'b1;
    sv = 0; sl = 0; sd = '0; st = '0;
    sv4 = 0; sl4 = 0; sd4 = '0; st4 = '0;
    idle(3);
    rst = 1'b0;
    check_reset_values("reset");
    check_eq("reset_dist4", o_dist4, 32'hFFFFFF);
    check_eq("reset_cnt4",  o_cnt4,  32'd0);

    // Basic batch on consecutive cycles
    send(50, 1, 0);
    check_eq("busy_collect", o_busy, 32'd1);
    check_eq("count_first",  o_cnt,  32'd1);
    send(20, 2, 0);
    send(80, 0, 0);
    send(10, 3, 0);
    send(20, 1, 1);
    check_basic_result("basic");
    check_eq("basic_busy", o_busy, 32'd0);
    hold_d = o_dist;
    hold_t = o_type;
    idle(3);
    check_eq("hold_dist", o_dist, hold_d);
    check_eq("hold_type", o_type, hold_t);
    check_eq("hold_vs",   o_vs,   32'd0);

    // Short batch with an all-ones distance
    send(5, 1, 0);
    send(255, 2, 1);
    check_eq("short_dist",  o_dist, 32'hFFFF05);
    check_eq("short_type",  o_type, 32'h09);
    check_eq("short_mask",  o_mask, 32'h3);
    check_eq("short_count", o_cnt,  32'd2);
    idle(2);

    // Back-to-back batches
    send(30, 1, 0);
    send(40, 2, 1);
    send(7, 2, 0);
    check_eq("b2b_vs",    o_vs,        32'd0);
    check_eq("b2b_dist0", o_dist[7:0], 32'd7);
    check_eq("b2b_type0", o_type[1:0], 32'd2);
    check_eq("b2b_mask",  o_mask,      32'h1);
    check_eq("b2b_busy",  o_busy,      32'd1);
    send(9, 0, 1);
    idle(2);

    // Same basic batch with 0-3 idle cycles between samples
    send(50, 1, 0); idle($urandom_range(0, 3));
    send(20, 2, 0); idle($urandom_range(0, 3));
    send(80, 0, 0); idle($urandom_range(0, 3));
    sl = 1'b1;      // last without valid must be ignored
    idle(1);
    send(10, 3, 0); idle($urandom_range(0, 3));
    send(20, 1, 1);
    check_basic_result("gaps");
    idle(1);

    // Reset mid-batch, asserted together with a sample
    send(50, 1, 0);
    send(20, 2, 0);
    rst = 1'b1;
    sv = 1'b1; sd = 8'd3; st = 2'd1; sl = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sv = 1'b0; sl = 1'b0;
    model_reset();
    check_reset_values("midrst");
    idle(3);
    check_eq("midrst_no_vs", o_vs, 32'd0);
    send(50, 1, 0);
    send(20, 2, 0);
    send(80, 0, 0);
    send(10, 3, 0);
    send(20, 1, 1);
    check_basic_result("after_rst");

    // Random batches: ties, all-ones distances, overflow at 16, gaps
    for (int b = 0; b < 8; b++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int s = 0; s < len; s++) begin
        int d;
        d = ($urandom_range(0, 3) == 0) ? 255 : $urandom_range(0, 15) * 16;
        send(d, $urandom_range(0, 3), s == len - 1);
        idle($urandom_range(0, 2));
      end
    end
    idle(2);

    // Overflow on the MAX_ELEMENTS = 4 instance
    send4(30, 1);
    send4(10, 2);
    send4(40, 3);
    check_eq("ovf_busy_mid", o_busy4, 32'd1);
    check_eq("ovf_vs_mid",   o_vs4,   32'd0);
    send4(20, 0);
    check_eq("ovf_vs",    o_vs4,   32'd1);
    check_eq("ovf_dist",  o_dist4, 32'h1E140A);
    check_eq("ovf_type",  o_type4, 32'h12);
    check_eq("ovf_count", o_cnt4,  32'd4);
    check_eq("ovf_busy",  o_busy4, 32'd0);
    send4(9, 1);
    check_eq("ovf_new_vs",    o_vs4,        32'd0);
    check_eq("ovf_new_count", o_cnt4,       32'd1);
    check_eq("ovf_new_busy",  o_busy4,      32'd1);
    check_eq("ovf_new_mask",  o_mask4,      32'h1);
    check_eq("ovf_new_dist0", o_dist4[7:0], 32'd9);

    idle(2);
    check_eq("scoreboard_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
